// File: rtl/aib_axi_deskew_pkg.sv
// aib_axi_deskew_pkg: shared deskew FSM states and alignment-marker constants.
package aib_axi_deskew_pkg;
  localparam int MARKER_W = 16;
  localparam logic [MARKER_W-1:0] ALIGN_PATTERN_DEF = 16'hA5C3;
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERROR} state_t;
endpackage

// File: rtl/aib_deskew_fifo.sv
// aib_deskew_fifo: single-clock per-channel deskew FIFO; extra pointer bit separates full from empty.
module aib_deskew_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 80
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a pop frees the slot in the same cycle, so push onto a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign count = wr - rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wr == rd;
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + (AW+1)'(do_push);
      rd <= rd + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/aib_axi_chnl_deskew.sv
// aib_axi_chnl_deskew: marker-hunts each AIB channel, buffers early ones and releases all in lockstep.
// Define AIB_AXI_DESKEW_STATS_EN to add skew_max, marker_mismatch and partial-marker errors.
module aib_axi_chnl_deskew
  import aib_axi_deskew_pkg::*;
#(
  parameter int NBR_CHNLS = 4,
  parameter int CHNL_DWIDTH = 80,
  parameter int FIFO_DEPTH = 8,
  parameter logic [MARKER_W-1:0] ALIGN_PATTERN = ALIGN_PATTERN_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                             clk_wr,
  input  logic                             rst_wr,
  input  logic                             align_start,
  input  logic [NBR_CHNLS-1:0]             rx_online,
  input  logic [NBR_CHNLS-1:0]             rx_vld,
  input  logic [NBR_CHNLS*CHNL_DWIDTH-1:0] rx_data,
  output logic [NBR_CHNLS*CHNL_DWIDTH-1:0] data_out,
  output logic                             data_out_vld,
  output logic                             align_done,
  output logic                             align_err,
  output logic [NBR_CHNLS-1:0]             marker_seen
`ifdef AIB_AXI_DESKEW_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]      skew_max,
  output logic                             marker_mismatch
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int DW = NBR_CHNLS * CHNL_DWIDTH;
  state_t st, st_n;
  logic [NBR_CHNLS-1:0] marker, push, full, empty, seen_n;
  logic [NBR_CHNLS-1:0][CW-1:0] cnt;
  logic [DW-1:0] head;
  logic [TW-1:0] tmo;
  logic online, restart, pop, flush, ovf, err_x;
  for (genvar c = 0; c < NBR_CHNLS; c++) begin : g_ch
    assign marker[c] = rx_vld[c] &&
      rx_data[c*CHNL_DWIDTH + CHNL_DWIDTH - MARKER_W +: MARKER_W] == ALIGN_PATTERN;
    aib_deskew_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CHNL_DWIDTH)) u_fifo (
      .clk(clk_wr),
      .rst(rst_wr),
      .push(push[c]),
      .pop(pop),
      .flush(flush),
      .din(rx_data[c*CHNL_DWIDTH +: CHNL_DWIDTH]),
      .dout(head[c*CHNL_DWIDTH +: CHNL_DWIDTH]),
      .full(full[c]),
      .empty(empty[c]),
      .count(cnt[c])
    );
  end
  assign online = &rx_online;
  assign restart = align_start && online;
  assign seen_n = marker_seen | marker;
  assign pop = st == LOCKED && !(|empty);
  // markers never enter a FIFO; before its own marker a channel's words are discarded
  assign push = st == HUNT ? rx_vld & ~marker & marker_seen : st == LOCKED ? rx_vld & ~marker : '0;
  assign ovf = |(push & full) && !pop;
  assign align_done = st == LOCKED;
  assign align_err = st == ERROR;
  always_ff @(posedge clk_wr or posedge rst_wr)
    if (rst_wr) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    if (st != IDLE && !online) st_n = IDLE;
    else if (restart) st_n = HUNT;
    else if (st == HUNT) st_n = (ovf || tmo == TW'(TIMEOUT_CYC - 1)) ? ERROR : &seen_n ? LOCKED : HUNT;
    else if (st == LOCKED && (ovf || err_x)) st_n = ERROR;
  end
  assign flush = restart || (st_n != HUNT && st_n != LOCKED);
  always_ff @(posedge clk_wr or posedge rst_wr)
    if (rst_wr) begin
      tmo <= '0;
      marker_seen <= '0;
      data_out <= '0;
      data_out_vld <= 1'b0;
    end else begin
      tmo <= restart ? '0 : st == HUNT ? tmo + 1'b1 : tmo;
      marker_seen <= restart ? '0 : st == HUNT ? seen_n : marker_seen;
      data_out_vld <= pop && !flush;
      if (pop && !flush) data_out <= head;
    end
`ifdef AIB_AXI_DESKEW_STATS_EN
  logic [CW-1:0] spread, hi, lo, occ;
  assign err_x = st == LOCKED && |marker && !(&marker);
  // occupancy spread after this cycle's pushes, i.e. as the FIFOs stand on entering LOCKED
  always_comb begin
    hi = '0;
    lo = '1;
    occ = '0;
    for (int c = 0; c < NBR_CHNLS; c++) begin
      occ = cnt[c] + CW'(push[c]);
      hi = occ > hi ? occ : hi;
      lo = occ < lo ? occ : lo;
    end
    spread = hi - lo;
  end
  always_ff @(posedge clk_wr or posedge rst_wr)
    if (rst_wr) begin
      skew_max <= '0;
      marker_mismatch <= 1'b0;
    end else begin
      marker_mismatch <= err_x;
      skew_max <= restart ? '0 : (st == HUNT && st_n == LOCKED && spread > skew_max) ? spread : skew_max;
    end
`else
  logic unused_cnt;
  assign err_x = 1'b0;
  assign unused_cnt = ^cnt;
`endif
endmodule

// File: tb/tb_aib_axi_chnl_deskew.sv
// tb_aib_axi_chnl_deskew: directed + random stimulus against a queue-based model of the deskew rules.
module tb_aib_axi_chnl_deskew;
  localparam int N = 4, W = 80, D = 8, TO = 1024, DW = N * W;
  localparam logic [15:0] PAT = 16'hA5C3;
  localparam int S_IDLE = 0, S_HUNT = 1, S_LOCK = 2, S_ERR = 3;
  logic clk_wr = 1'b0;
  logic rst_wr, align_start;
  logic [N-1:0] rx_online, rx_vld, marker_seen;
  logic [DW-1:0] rx_data, data_out;
  logic data_out_vld, align_done, align_err;
`ifdef AIB_AXI_DESKEW_STATS_EN
  logic [$clog2(D):0] skew_max;
  logic marker_mismatch;
`endif
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] q[N][$];
  int m_st, m_tc, m_skew;
  logic [N-1:0] m_seen;
  logic [DW-1:0] m_out;
  logic m_vld, m_mm;

  aib_axi_chnl_deskew #(.NBR_CHNLS(N), .CHNL_DWIDTH(W), .FIFO_DEPTH(D), .ALIGN_PATTERN(PAT),
                        .TIMEOUT_CYC(TO)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .align_start(align_start), .rx_online(rx_online),
    .rx_vld(rx_vld), .rx_data(rx_data), .data_out(data_out), .data_out_vld(data_out_vld),
    .align_done(align_done), .align_err(align_err), .marker_seen(marker_seen)
`ifdef AIB_AXI_DESKEW_STATS_EN
    , .skew_max(skew_max), .marker_mismatch(marker_mismatch)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mflush();
    for (int c = 0; c < N; c++) q[c].delete();
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_tc = 0; m_skew = 0; m_seen = '0; m_out = '0; m_vld = 1'b0; m_mm = 1'b0;
    mflush();
  endtask

  task automatic model_step();
    logic [N-1:0] mk;
    logic [DW-1:0] fr;
    logic on, pp, ovf, part, err;
    int hi, lo;
    on = &rx_online;
    for (int c = 0; c < N; c++) mk[c] = rx_vld[c] && rx_data[c*W + W - 16 +: 16] == PAT;
    part = |mk && !(&mk);
    m_mm = m_st == S_LOCK && part;
    m_vld = 1'b0;
    if (m_st != S_IDLE && !on) begin
      m_st = S_IDLE; mflush();
    end else if (align_start && on) begin
      m_st = S_HUNT; mflush(); m_seen = '0; m_tc = 0; m_skew = 0;
    end else if (m_st == S_HUNT) begin
      ovf = 1'b0;
      for (int c = 0; c < N; c++)
        if (mk[c]) m_seen[c] = 1'b1;
        else if (rx_vld[c] && m_seen[c]) begin
          q[c].push_back(rx_data[c*W +: W]);
          ovf |= q[c].size() > D;
        end
      if (ovf || m_tc == TO - 1) begin
        m_st = S_ERR; mflush();
      end else if (&m_seen) begin
        m_st = S_LOCK;
        hi = 0; lo = D + 1;
        for (int c = 0; c < N; c++) begin
          hi = q[c].size() > hi ? q[c].size() : hi;
          lo = q[c].size() < lo ? q[c].size() : lo;
        end
        if (hi - lo > m_skew) m_skew = hi - lo;
      end
      m_tc++;
    end else if (m_st == S_LOCK) begin
      pp = 1'b1;
      fr = '0;
      for (int c = 0; c < N; c++) pp &= q[c].size() > 0;
      if (pp) for (int c = 0; c < N; c++) fr[c*W +: W] = q[c].pop_front();
      ovf = 1'b0;
      for (int c = 0; c < N; c++)
        if (rx_vld[c] && !mk[c]) begin
          q[c].push_back(rx_data[c*W +: W]);
          ovf |= q[c].size() > D;
        end
      err = ovf;
`ifdef AIB_AXI_DESKEW_STATS_EN
      err |= part;
`endif
      if (err) begin
        m_st = S_ERR; mflush();
      end else if (pp) begin
        m_out = fr; m_vld = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_wr); #1;
    chk("status", DW'({align_done, align_err, data_out_vld, marker_seen}),
        DW'({m_st == S_LOCK, m_st == S_ERR, m_vld, m_seen}));
    chk("data_out", data_out, m_out);
`ifdef AIB_AXI_DESKEW_STATS_EN
    chk("stats", DW'({skew_max, marker_mismatch}), DW'({4'(m_skew), m_mm}));
`endif
  endtask

  task automatic drive(int c, bit v, bit mk);
    logic [W-1:0] w;
    w = W'({$urandom, $urandom, $urandom});
    if (w[W-1 -: 16] == PAT) w[W-1] = ~w[W-1];
    if (mk) w[W-1 -: 16] = PAT;
    rx_vld[c] = v;
    rx_data[c*W +: W] = w;
  endtask

  task automatic drive_all(bit v, logic [N-1:0] mk);
    for (int c = 0; c < N; c++) drive(c, v || mk[c], mk[c]);
  endtask

  task automatic start();
    align_start = 1'b1;
    drive_all(1'b0, '0);
    tick();
    align_start = 1'b0;
  endtask

  initial begin
    int n;
    rst_wr = 1'b1; align_start = 1'b0; rx_online = '1; rx_vld = '0; rx_data = '0;
    model_reset();
    repeat (2) @(posedge clk_wr);
    #1;
    chk("reset", DW'({align_done, align_err, data_out_vld, marker_seen}), '0);
    chk("reset_data", data_out, '0);
    rst_wr = 1'b0;
    // zero skew: common marker then ten words
    start();
    drive_all(1'b1, '1);
    tick();
    chk("zd_lock", DW'(align_done), DW'(1));
    n = 0;
    for (int k = 0; k < 14; k++) begin
      drive_all(k < 10, '0);
      tick();
      n += int'(data_out_vld);
    end
    chk("zd_count", DW'(n), DW'(10));
    // channel 2 three cycles late
    start();
    drive_all(1'b1, 4'b1011);
    tick();
    for (int k = 1; k <= 3; k++) begin
      drive_all(1'b1, '0);
      if (k == 3) drive(2, 1'b1, 1'b1);
      tick();
    end
    chk("sk3_lock", DW'(align_done), DW'(1));
`ifdef AIB_AXI_DESKEW_STATS_EN
    chk("sk3_skew_max", DW'(skew_max), DW'(3));
`endif
    for (int k = 0; k < 26; k++) begin
      drive_all(k < 20 && $urandom_range(0, 3) != 0, '0);
      tick();
    end
    // channel 3 eight cycles late overflows the early FIFOs
    start();
    drive_all(1'b0, 4'b0111);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive_all(1'b1, '0);
      drive(3, k == 8, k == 8);
      tick();
    end
    drive_all(1'b1, '0);
    tick();
    chk("sk8_err", DW'(align_err), DW'(1));
    repeat (3) tick();
    chk("sk8_err_vld", DW'(data_out_vld), DW'(0));
    start();
    chk("sk8_recover", DW'({align_err, align_done}), DW'(0));
    // timeout with only channel 0 ever marked
    start();
    drive_all(1'b0, 4'b0001);
    tick();
    n = 1;
    while (!align_err && n < 1100) begin
      for (int c = 1; c < N; c++) drive(c, 1'($urandom_range(0, 1)), 1'b0);
      rx_vld[0] = 1'b0;
      tick();
      n++;
    end
    chk("timeout_cyc", DW'(n), DW'(TO));
    chk("timeout_seen", DW'(marker_seen), DW'(4'b0001));
    // link drop while locked
    start();
    drive_all(1'b1, '1);
    tick();
    repeat (5) begin drive_all(1'b1, '0); tick(); end
    rx_online[1] = 1'b0;
    drive_all(1'b1, '0);
    tick();
    chk("drop_idle", DW'({align_done, align_err, data_out_vld}), DW'(0));
    rx_online = '1;
    drive_all(1'b0, '0);
    tick();
    start();
    drive_all(1'b1, '1);
    tick();
    drive_all(1'b1, '0);
    tick();
    drive_all(1'b0, '0);
    repeat (3) tick();
    // markers on channels 0 and 1 only while locked
    drive_all(1'b0, 4'b0011);
    tick();
`ifdef AIB_AXI_DESKEW_STATS_EN
    chk("partial", DW'({align_err, marker_mismatch}), DW'(2'b11));
`else
    chk("partial", DW'(align_done), DW'(1));
`endif
    // asynchronous reset in the middle of a hunt
    start();
    drive_all(1'b0, 4'b0001);
    tick();
    drive_all(1'b0, '0);
    #2 rst_wr = 1'b1;
    #1;
    chk("async_rst", DW'({align_done, align_err, data_out_vld, marker_seen}), '0);
    chk("async_rst_data", data_out, '0);
    model_reset();
    @(posedge clk_wr);
    #1 rst_wr = 1'b0;
    // random soak
    for (int i = 0; i < 400; i++) begin
      align_start = $urandom_range(0, 24) == 0;
      rx_online = $urandom_range(0, 40) == 0 ? N'($urandom) : '1;
      for (int c = 0; c < N; c++) drive(c, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
